// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous data memory between
// the core load/store port and an auxiliary requester.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic              core_gnt_q, aux_gnt_q, core_rvalid_q, aux_rvalid_q;
  logic              mem_wr_q, mem_rd_q, last_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              core_elig, aux_elig, pick_aux, win, win_we;
  // A requester in its grant cycle is still holding req for that access, so it is masked.
  always_comb begin
    core_elig = core_req & ~core_gnt_q;
    aux_elig  = aux_req & ~aux_gnt_q;
    pick_aux  = aux_elig & (~core_elig | ~last_q);
    win       = core_elig | aux_elig;
    win_we    = pick_aux ? aux_we : core_we;
  end
  // last_q: 1 = aux granted last, so the core wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_gnt_q    <= 1'b0;
      aux_gnt_q     <= 1'b0;
      core_rvalid_q <= 1'b0;
      aux_rvalid_q  <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      last_q        <= 1'b1;
    end else begin
      core_gnt_q    <= win & ~pick_aux;
      aux_gnt_q     <= pick_aux;
      mem_wr_q      <= win & win_we;
      mem_rd_q      <= win & ~win_we;
      core_rvalid_q <= core_gnt_q & mem_rd_q;
      aux_rvalid_q  <= aux_gnt_q & mem_rd_q;
      if (win) begin
        mem_addr_q  <= pick_aux ? aux_addr : core_addr;
        mem_wdata_q <= pick_aux ? aux_wdata : core_wdata;
        last_q      <= pick_aux;
      end
    end
  end
  assign core_gnt    = core_gnt_q;
  assign aux_gnt     = aux_gnt_q;
  assign core_rvalid = core_rvalid_q;
  assign aux_rvalid  = aux_rvalid_q;
  assign core_rdata  = mem_rdata;
  assign aux_rdata   = mem_rdata;
  assign core_stall  = core_req & ~core_gnt_q;
  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
endmodule
